// File: rtl/param_shift_register.sv
// param_shift_register: WIDTH-bit staging/serialisation register with clock
// enable, single-cycle load/shift/rotate/set operations and a sequenced
// multi-position shift engine that reports progress through busy/done.
module param_shift_register #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    parameter int               CNT_W   = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic [2:0]       mode,
    input  logic             start,
    input  logic [CNT_W-1:0] amt,
    input  logic             sin_l,
    input  logic             sin_r,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             sout_l,
    output logic             sout_r,
    output logic             busy,
    output logic             done
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic [2:0] M_HOLD = 3'b000;
    localparam logic [2:0] M_LOAD = 3'b001;
    localparam logic [2:0] M_SHL  = 3'b010;
    localparam logic [2:0] M_SHR  = 3'b011;
    localparam logic [2:0] M_ROTL = 3'b100;
    localparam logic [2:0] M_ROTR = 3'b101;
    localparam logic [2:0] M_ASHR = 3'b110;
    localparam logic [2:0] M_SET  = 3'b111;

    logic [0:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       mode_q;

    // One-position step of the selected operation.
    function automatic logic [WIDTH-1:0] step_op(
        input logic [2:0]       m,
        input logic [WIDTH-1:0] cur,
        input logic [WIDTH-1:0] d,
        input logic             sl,
        input logic             sr
    );
        logic signed [WIDTH-1:0] s;
        logic [WIDTH-1:0]        r;
        s = signed'(cur);
        case (m)
            M_HOLD:  r = cur;
            M_LOAD:  r = d;
            M_SHL:   r = {cur[WIDTH-2:0], sr};
            M_SHR:   r = {sl, cur[WIDTH-1:1]};
            M_ROTL:  r = {cur[WIDTH-2:0], cur[WIDTH-1]};
            M_ROTR:  r = {cur[0], cur[WIDTH-1:1]};
            M_ASHR:  r = s >>> 1;
            M_SET:   r = '1;
            default: r = cur;
        endcase
        return r;
    endfunction

    // Only the shift/rotate family can be sequenced over several positions.
    function automatic logic is_multi(input logic [2:0] m);
        return (m >= M_SHL) && (m <= M_ASHR);
    endfunction

    assign sout_l = dout[WIDTH-1];
    assign sout_r = dout[0];
    assign busy   = (state == S_RUN);

    // Register, shift engine FSM and done pulse; done self-clears every edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout   <= RST_VAL;
            state  <= S_IDLE;
            cnt    <= '0;
            mode_q <= M_HOLD;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (ce) begin
                case (state)
                    S_IDLE: begin
                        if (start && is_multi(mode) && (amt != '0)) begin
                            // Capture the operation; shifting starts next edge.
                            mode_q <= mode;
                            cnt    <= amt;
                            state  <= S_RUN;
                        end else begin
                            dout <= step_op(mode, dout, din, sin_l, sin_r);
                            if (start) begin
                                done <= 1'b1;
                            end
                        end
                    end
                    S_RUN: begin
                        // Serial inputs stay live; mode, din and start are ignored.
                        dout <= step_op(mode_q, dout, din, sin_l, sin_r);
                        if (cnt == CNT_W'(1)) begin
                            cnt   <= '0;
                            state <= S_IDLE;
                            done  <= 1'b1;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_param_shift_register.sv
// Scoreboard bench for param_shift_register (WIDTH=8, RST_VAL=8'hA5).
module tb_param_shift_register;

    localparam int         W   = 8;
    localparam int         CW  = 4;
    localparam logic [7:0] RSV = 8'hA5;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          ce = 1'b0;
    logic [2:0]    mode = 3'b000;
    logic          start = 1'b0;
    logic [CW-1:0] amt = '0;
    logic          sin_l = 1'b0;
    logic          sin_r = 1'b0;
    logic [W-1:0]  din = '0;
    logic [W-1:0]  dout;
    logic          sout_l;
    logic          sout_r;
    logic          busy;
    logic          done;

    param_shift_register #(.WIDTH(W), .RST_VAL(RSV)) dut (
        .clk(clk), .rst(rst), .ce(ce), .mode(mode), .start(start), .amt(amt),
        .sin_l(sin_l), .sin_r(sin_r), .din(din), .dout(dout),
        .sout_l(sout_l), .sout_r(sout_r), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] v;
        logic       b;
        logic       d;
        string      tag;
    } exp_t;

    exp_t  sb[$];
    int    checks = 0;
    int    passes = 0;
    string phase = "reset";

    // Reference model state: register value, pending positions, captured op.
    int m_val;
    bit m_busy;
    bit m_done;
    int m_rem;
    int m_mode;

    function automatic int apply_op(int m, int v, int d, int sl, int sr);
        case (m)
            0: return v;
            1: return d;
            2: return ((v * 2) + sr) % 256;
            3: return sl * 128 + v / 2;
            4: return ((v * 2) + v / 128) % 256;
            5: return (v % 2) * 128 + v / 2;
            6: return (v / 128) * 128 + v / 2;
            default: return 255;
        endcase
    endfunction

    function automatic void push_exp();
        exp_t e;
        e.v = 8'(m_val);
        e.b = m_busy;
        e.d = m_done;
        e.tag = phase;
        sb.push_back(e);
    endfunction

    // Monitor: compare the DUT against the oldest pending expectation.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if ({dout, busy, done, sout_l, sout_r} === {e.v, e.b, e.d, e.v[7], e.v[0]}) begin
                passes++;
            end else begin
                $display("FAIL %s: got dout=%h busy=%b done=%b sout_l=%b sout_r=%b, want dout=%h busy=%b done=%b",
                         e.tag, dout, busy, done, sout_l, sout_r, e.v, e.b, e.d);
            end
        end
    end

    // One clock of stimulus; the model predicts the state after the edge.
    task automatic cycle(input logic c, input logic [2:0] md, input logic st,
                         input logic [CW-1:0] a, input logic sl, input logic sr,
                         input logic [7:0] d);
        bit nd;
        ce = c; mode = md; start = st; amt = a; sin_l = sl; sin_r = sr; din = d;
        nd = 1'b0;
        if (c) begin
            if (m_busy) begin
                m_val = apply_op(m_mode, m_val, int'(d), int'(sl), int'(sr));
                m_rem = m_rem - 1;
                if (m_rem == 0) begin
                    m_busy = 1'b0;
                    nd = 1'b1;
                end
            end else if (st && md >= 3'd2 && md <= 3'd6 && a != 0) begin
                m_busy = 1'b1;
                m_rem  = int'(a);
                m_mode = int'(md);
            end else begin
                m_val = apply_op(int'(md), m_val, int'(d), int'(sl), int'(sr));
                if (st) nd = 1'b1;
            end
        end
        m_done = nd;
        @(posedge clk);
        push_exp();
        #1;
    endtask

    task automatic idle(input int n, input logic sl, input logic sr);
        for (int i = 0; i < n; i++) cycle(1'b1, 3'b000, 1'b0, '0, sl, sr, 8'h00);
    endtask

    // Asynchronous reset right after an edge: the checked state must already
    // be RST_VAL at the following falling edge, with no rising edge between.
    task automatic do_reset();
        if (sb.size() > 0) void'(sb.pop_back());
        rst = 1'b1;
        start = 1'b0;
        m_val = int'(RSV); m_busy = 1'b0; m_done = 1'b0; m_rem = 0; m_mode = 0;
        push_exp();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        m_val = int'(RSV); m_busy = 1'b0; m_done = 1'b0; m_rem = 0; m_mode = 0;
        push_exp();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        phase = "single_steps";
        cycle(1, 3'b001, 0, 0, 0, 0, 8'h81);
        cycle(1, 3'b010, 0, 0, 0, 1, 8'h00);
        cycle(1, 3'b101, 0, 0, 0, 0, 8'h00);
        cycle(1, 3'b110, 0, 0, 0, 0, 8'h00);
        cycle(1, 3'b111, 0, 0, 0, 0, 8'h00);
        phase = "ce_hold";
        cycle(0, 3'b001, 0, 0, 0, 0, 8'h00);
        cycle(0, 3'b001, 0, 0, 0, 0, 8'h00);

        phase = "rotl3";
        cycle(1, 3'b001, 0, 0, 0, 0, 8'h01);
        cycle(1, 3'b100, 1, 4'd3, 0, 0, 8'h00);
        idle(3, 0, 0);
        cycle(0, 3'b000, 0, 0, 0, 0, 8'h00);
        idle(1, 0, 0);

        phase = "rotl3_ce_gap";
        cycle(1, 3'b001, 0, 0, 0, 0, 8'h01);
        cycle(1, 3'b100, 1, 4'd3, 0, 0, 8'h00);
        idle(1, 0, 0);
        cycle(0, 3'b000, 0, 0, 0, 0, 8'h00);
        cycle(0, 3'b000, 0, 0, 0, 0, 8'h00);
        idle(3, 0, 0);

        phase = "amt_zero";
        cycle(1, 3'b000, 1, 4'd0, 0, 0, 8'h00);
        idle(2, 0, 0);
        cycle(1, 3'b010, 1, 4'd0, 0, 1, 8'h00);
        idle(1, 0, 0);

        phase = "start_in_run";
        cycle(1, 3'b001, 0, 0, 0, 0, 8'h01);
        cycle(1, 3'b100, 1, 4'd3, 0, 0, 8'h00);
        cycle(1, 3'b010, 1, 4'd5, 0, 1, 8'h55);
        cycle(1, 3'b011, 1, 4'd7, 1, 0, 8'h00);
        idle(3, 0, 0);

        phase = "shr9_flush";
        cycle(1, 3'b001, 0, 0, 0, 0, 8'hFF);
        cycle(1, 3'b011, 1, 4'd9, 0, 0, 8'h00);
        idle(11, 0, 0);

        phase = "abort";
        cycle(1, 3'b001, 0, 0, 0, 0, 8'h0F);
        cycle(1, 3'b010, 1, 4'd5, 0, 0, 8'h00);
        idle(2, 0, 0);
        do_reset();
        idle(6, 0, 0);
        phase = "after_abort";
        cycle(1, 3'b101, 1, 4'd2, 0, 0, 8'h00);
        idle(3, 0, 0);

        phase = "random";
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end else begin
                cycle(1'($urandom_range(0, 5) != 0), 3'($urandom_range(0, 7)),
                      1'($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      8'($urandom_range(0, 255)));
            end
        end
        idle(16, 0, 0);

        @(negedge clk);
        #1;
        checks++;
        if (sb.size() == 0) begin
            passes++;
        end else begin
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
